// File: rtl/aes_key_sched.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry register file,
// served through a combinational read port. Optional macro AES_KEY_SCHED_EQINV_EN adds
// Equivalent Inverse Cipher keys on the read path when decrypt_i=1.

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t   = a;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      t   = gmul(t, t);
      inv = gmul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign o_byte = sbox(i_byte);
endmodule

module aes_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         keys_valid_o,
  input  logic         decrypt_i,
  input  logic [3:0]   rd_round_i,
  output logic [127:0] rd_key_o
);
  if (NR != 10) begin : g_nr_check
    $error("aes_key_sched supports only NR=10 (AES-128)");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic         r_keys_valid;
  logic         r_busy;
  logic [127:0] r_rk [0:10];

  logic [3:0]   w_prev_idx;
  logic [127:0] w_prev_rk;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [7:0]   w_rcon;
  logic [31:0]  w_temp;
  logic [127:0] w_next_rk;
  logic [127:0] w_rd_raw;

  assign w_prev_idx = r_cnt - 4'd1;

  always_comb begin
    w_prev_rk = 128'h0;
    if (w_prev_idx <= 4'd10) w_prev_rk = r_rk[w_prev_idx];
  end

  always_comb begin
    case (r_cnt)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  // RotWord on w3, then SubWord through four parallel S-boxes.
  assign w_rot = {w_prev_rk[23:0], w_prev_rk[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_rot[8*gi +: 8]),
      .o_byte (w_sub[8*gi +: 8])
    );
  end

  assign w_temp              = w_sub ^ {w_rcon, 24'h0};
  assign w_next_rk[127:96]   = w_prev_rk[127:96] ^ w_temp;
  assign w_next_rk[95:64]    = w_prev_rk[95:64]  ^ w_next_rk[127:96];
  assign w_next_rk[63:32]    = w_prev_rk[63:32]  ^ w_next_rk[95:64];
  assign w_next_rk[31:0]     = w_prev_rk[31:0]   ^ w_next_rk[63:32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_keys_valid <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 0; i < 11; i++) r_rk[i] <= 128'h0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: begin
          if (key_valid_i) begin
            r_rk[0]      <= key_i;
            r_cnt        <= 4'd1;
            r_state      <= S_EXPAND;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        S_EXPAND: begin
          if (r_cnt <= 4'd10) r_rk[r_cnt] <= w_next_rk;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd10) begin
            r_state      <= S_READY;
            r_keys_valid <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_ready_o  = !rst_i && (r_state != S_EXPAND);
  assign busy_o       = r_busy;
  assign keys_valid_o = r_keys_valid;

  always_comb begin
    w_rd_raw = 128'h0;
    if (rd_round_i <= 4'd10) w_rd_raw = r_rk[rd_round_i];
  end

`ifdef AES_KEY_SCHED_EQINV_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = w;
    return {gm(s0, 8'h0e) ^ gm(s1, 8'h0b) ^ gm(s2, 8'h0d) ^ gm(s3, 8'h09),
            gm(s0, 8'h09) ^ gm(s1, 8'h0e) ^ gm(s2, 8'h0b) ^ gm(s3, 8'h0d),
            gm(s0, 8'h0d) ^ gm(s1, 8'h09) ^ gm(s2, 8'h0e) ^ gm(s3, 8'h0b),
            gm(s0, 8'h0b) ^ gm(s1, 8'h0d) ^ gm(s2, 8'h09) ^ gm(s3, 8'h0e)};
  endfunction

  logic [127:0] w_rd_inv;

  for (genvar gi = 0; gi < 4; gi++) begin : g_invmix
    assign w_rd_inv[32*gi +: 32] = inv_mix_col(w_rd_raw[32*gi +: 32]);
  end

  // Rounds 0 and 10 bypass InvMixColumns in the equivalent inverse cipher.
  assign rd_key_o = (decrypt_i && rd_round_i >= 4'd1 && rd_round_i <= 4'd9) ? w_rd_inv : w_rd_raw;
`else
  logic w_unused_decrypt;
  assign w_unused_decrypt = decrypt_i;
  assign rd_key_o = w_rd_raw;
`endif
endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
Iterative AES-128 key expansion unit that feeds round keys to the aes_round datapath.
- Accepts a 128-bit cipher key through a valid/ready handshake.
- Generates the 10 round keys at one per clock and holds all 11 (round 0..10) in an internal register file.
- Serves keys through a combinational random-access read port indexed by round number.
- The round controller reads ascending indices for encrypt and descending indices for decrypt.

Parameters:
NR, 10, number of AES rounds. The only supported value is 10 (AES-128); any other value is an elaboration error.

Ports:
clk_i  input  1  system clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
key_valid_i  input  1  cipher key present on key_i
key_ready_o  output  1  block can accept a new key
key_i  input  128  cipher key; key_i[127:120] is FIPS-197 byte 0, key_i[127:96] is w0
busy_o  output  1  expansion in progress
keys_valid_o  output  1  all 11 round keys are valid and stable
decrypt_i  input  1  read-port mode select; only used with the optional feature
rd_round_i  input  4  round-key index, 0..10
rd_key_o  output  128  round key for rd_round_i, combinational from the register file

Behaviour:
- States:
  - IDLE: no keys.
  - EXPAND: generating keys.
  - READY: keys valid.
- Reset (rst_i=1 at a rising edge):
  - State goes to IDLE, round counter to 0, all 11 register-file entries to 0.
  - keys_valid_o=0, busy_o=0.
  - key_ready_o is forced 0 while rst_i=1.
- key_ready_o = !rst_i & (state != EXPAND). Handshake completes at a rising edge where key_valid_i & key_ready_o.
- On handshake (from IDLE or READY):
  - rk[0] <= key_i, cnt <= 1, state <= EXPAND.
  - keys_valid_o falls at that same edge. Keys from a previous load are not guaranteed after this point.
- EXPAND, per cycle:
  - Compute rk[cnt] from rk[cnt-1] per FIPS-197: temp = SubWord(RotWord(w3)) ^ {Rcon[cnt],24'h0}; w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Then cnt <= cnt+1.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - Four S-box instances, combinational.
- When rk[10] is written (cnt==10):
  - state <= READY, keys_valid_o <= 1, at that same edge.
  - Latency: handshake at edge N gives keys_valid_o=1 after edge N+10.
- busy_o = (state == EXPAND).
- key_valid_i during EXPAND is ignored (ready=0); the key is not captured.
- key_i only needs to be stable on the handshake edge.
- Read port:
  - rd_key_o = rk[rd_round_i] in any state.
  - Index 11..15 returns 128'h0.
  - Contents are meaningful only when keys_valid_o=1; in IDLE after reset the port reads 0.
- Reset mid-EXPAND aborts the expansion and clears everything; there is no partial keys_valid_o.
- Back-to-back loads:
  - A new key may be accepted on the first cycle in READY.
  - The round key read in the same cycle as that handshake is still the old key.

Optional Feature:
AES_KEY_SCHED_EQINV_EN
- Defined, with decrypt_i=1: rd_key_o returns InvMixColumns(rk[i]) for i=1..9 and rk[i] unmodified for i=0 and 10. These are the Equivalent Inverse Cipher keys, FIPS-197 5.3.5. The transform is combinational on the read path; register-file contents are unchanged.
- Defined, with decrypt_i=0: identical to undefined.
- Undefined: decrypt_i is unused and rd_key_o is always rk[rd_round_i]; no InvMixColumns logic is instantiated.

Test Plan:
1. Reset, then load key 2b7e151628aed2a6abf7158809cf4f3c.
   - keys_valid_o rises exactly 10 cycles after the handshake; busy_o=1 for those 10 cycles.
   - rd_round_i=1 gives a0fafe1788542cb123a339392a6c7605; rd_round_i=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rd_round_i=0 gives the key itself.
2. All-zero key.
   - rk1 = 62636363626363636263636362636363.
   - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
   - rd_round_i=12 gives 0.
3. Key-load attempts during and after EXPAND.
   - Hold key_valid_i=1 with a different key during EXPAND: key_ready_o=0 throughout, and the first key's results from test 1 are unchanged.
   - Reload in READY: keys_valid_o drops at the handshake edge and returns after 10 cycles with the new keys.
4. Assert rst_i in cycle 5 of EXPAND.
   - Next cycle: keys_valid_o=0, busy_o=0, all read indices give 0.
   - key_ready_o=1 once rst_i deasserts.
5. With AES_KEY_SCHED_EQINV_EN defined, using the test-1 key:
   - decrypt_i=1, rd_round_i=0 and 10 give the same values as decrypt_i=0.
   - decrypt_i=1, rd_round_i=1..9 give InvMixColumns(rk[i]) as computed by the bench reference model.
   - With the macro undefined, decrypt_i toggling has no effect.
